i2c_cfg_responder: RTL and testbench

- I2C target (responder) that answers the DVI configuration master's writes and reads.
- Holds a byte-wide register bank, addressed by a register pointer that auto-increments.
- Serves as the far end of the DVI-encoder I2C link in simulation and in loopback builds on the board.
- Runs entirely in the 25 MHz pixel clock domain. SCL and SDA are oversampled; no SCL-clocked logic.

---
 rtl/i2c_pkg.sv | 35 +++
 rtl/i2c_line_filter.sv | 60 ++++++
 rtl/i2c_cfg_responder.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_i2c_cfg_responder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C configuration link: FSM state encoding,
// byte-phase encoding, default target address and filter limits.
package i2c_pkg;

  // Target address shared with the DVI configuration master.
  localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h76;

  // Glitch filter length limits; the counter is sized for the maximum.
  localparam int unsigned FILT_MAX   = 7;
  localparam int unsigned FILT_CNT_W = 3;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_IGNORE
  } state_e;

  // Position within a byte: shifting bits, byte complete (ACK due on the
  // next SCL fall), inside the ACK clock, or waiting to load the next
  // read byte on the next SCL fall.
  typedef enum logic [1:0] {
    PH_BITS,
    PH_DONE,
    PH_ACK,
    PH_LOAD
  } phase_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Oversampled input conditioning for one I2C line.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   raw        : asynchronous pad level
//   lvl        : synchronized, glitch-filtered level (reset value 1)
//   rise_c     : combinational one-cycle pulse on a filtered 0->1 change
//   fall_c     : combinational one-cycle pulse on a filtered 1->0 change
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic rise_c,
  output logic fall_c
);

  logic                  sync1_q, sync2_q;
  logic                  lvl_q, lvl_d;
  logic                  prev_q;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the filtered level; the
  // level flips on the FILT-th one, any agreeing sample restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == FILT_CNT_W'(FILT - 1)) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + FILT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl    = lvl_q;
  assign rise_c = lvl_q & ~prev_q;
  assign fall_c = ~lvl_q & prev_q;

endmodule

// File: rtl/i2c_cfg_responder.sv
// I2C target holding a byte-wide register bank with an auto-incrementing
// register pointer. Everything runs in the clk domain; SCL/SDA are
// oversampled through i2c_line_filter.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   scl_in     : raw SCL from the pad
//   sda_in     : raw SDA from the pad
//   sda_oe     : 1 pulls SDA low (open drain)
//   wr_stb     : one-cycle pulse per data byte written
//   wr_addr    : register index of the written byte
//   wr_data    : value of the written byte
//   dbg_addr   : debug read address
//   dbg_data   : bank[dbg_addr], combinational
//   busy       : high from START to STOP on the bus
module i2c_cfg_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int unsigned PTR_W    = 6,
  parameter int unsigned FILT     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] dbg_addr,
  output logic [7:0]       dbg_data,
  output logic             busy
);

  localparam int unsigned DEPTH = 2 ** PTR_W;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_c, stop_c;

  state_e               state_q, state_d;
  phase_e               ph_q, ph_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]    wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic [BYTE_W-1:0]    bank_q [DEPTH];
  logic [BYTE_W-1:0]    bank_d [DEPTH];

  logic [BYTE_W-1:0]    rx_byte_c;
  logic [BYTE_W-1:0]    rd_byte_c;
  logic                 last_bit_c;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (scl_in),
    .lvl    (scl_lvl),
    .rise_c (scl_rise),
    .fall_c (scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (sda_in),
    .lvl    (sda_lvl),
    .rise_c (sda_rise),
    .fall_c (sda_fall)
  );

  // Bus conditions: SDA moving while SCL is high.
  assign start_c    = sda_fall & scl_lvl;
  assign stop_c     = sda_rise & scl_lvl;

  // Byte as it will be once the current sampled bit is shifted in.
  assign rx_byte_c  = {shift_q[BYTE_W-2:0], sda_lvl};
  assign rd_byte_c  = bank_q[ptr_q];
  assign last_bit_c = (bit_cnt_q == BIT_CNT_W'(7));

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    bank_d    = bank_q;

    if (start_c) begin
      state_d   = ST_ADDR;
      ph_d      = PH_BITS;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_c) begin
      state_d   = ST_IDLE;
      ph_d      = PH_BITS;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise && ph_q == PH_BITS) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit_c) begin
              bit_cnt_d = '0;
              if (rx_byte_c[7:1] == DEV_ADDR) begin
                rw_d = rx_byte_c[0];
                ph_d = PH_DONE;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end else if (scl_fall && ph_q == PH_DONE) begin
            sda_oe_d = 1'b1;
            state_d  = ST_ADDR_ACK;
            ph_d     = PH_ACK;
          end
        end

        // The fall ending the ACK clock either releases SDA or puts the
        // first read bit on the line.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            ph_d      = PH_BITS;
            if (rw_q) begin
              state_d  = ST_RD_DATA;
              shift_d  = rd_byte_c;
              sda_oe_d = ~rd_byte_c[7];
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        // Pointer and write bytes share the shift/ACK sequence.
        ST_PTR, ST_WR_DATA: begin
          case (ph_q)
            PH_BITS: begin
              if (scl_rise) begin
                shift_d   = rx_byte_c;
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (last_bit_c) begin
                  bit_cnt_d = '0;
                  ph_d      = PH_DONE;
                  if (state_q == ST_PTR) begin
                    ptr_d = rx_byte_c[PTR_W-1:0];
                  end else begin
                    wr_stb_d      = 1'b1;
                    wr_addr_d     = ptr_q;
                    wr_data_d     = rx_byte_c;
                    bank_d[ptr_q] = rx_byte_c;
                    ptr_d         = ptr_q + PTR_W'(1);
                  end
                end
              end
            end
            PH_DONE: begin
              if (scl_fall) begin
                sda_oe_d = 1'b1;
                ph_d     = PH_ACK;
              end
            end
            PH_ACK: begin
              if (scl_fall) begin
                sda_oe_d = 1'b0;
                state_d  = ST_WR_DATA;
                ph_d     = PH_BITS;
              end
            end
            default: ph_d = PH_BITS;
          endcase
        end

        ST_RD_DATA: begin
          case (ph_q)
            PH_BITS: begin
              if (scl_rise) begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (last_bit_c) begin
                  bit_cnt_d = '0;
                  ph_d      = PH_DONE;
                end
              end else if (scl_fall) begin
                shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                sda_oe_d = ~shift_q[BYTE_W-2];
              end
            end
            // Release SDA so the master can drive its ACK/NACK.
            PH_DONE: begin
              if (scl_fall) begin
                sda_oe_d = 1'b0;
                ph_d     = PH_ACK;
              end
            end
            PH_ACK: begin
              if (scl_rise) begin
                if (!sda_lvl) begin
                  ptr_d = ptr_q + PTR_W'(1);
                  ph_d  = PH_LOAD;
                end else begin
                  state_d = ST_IGNORE;
                  ph_d    = PH_BITS;
                end
              end
            end
            PH_LOAD: begin
              if (scl_fall) begin
                shift_d   = rd_byte_c;
                sda_oe_d  = ~rd_byte_c[7];
                bit_cnt_d = '0;
                ph_d      = PH_BITS;
              end
            end
            default: ph_d = PH_BITS;
          endcase
        end

        ST_IDLE, ST_IGNORE: sda_oe_d = 1'b0;

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ph_q      <= PH_BITS;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      bank_q    <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      bank_q    <= bank_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign dbg_data = bank_q[dbg_addr];

endmodule

// File: tb/tb_i2c_cfg_responder.sv
// Bench for i2c_cfg_responder: a bit-banged I2C master drives the bus,
// expected ACK/read bytes and write strobes go into scoreboard queues and
// are popped by monitors when the DUT presents them.
module tb_i2c_cfg_responder;

  localparam int unsigned PTR_W = 6;
  localparam int unsigned FILT  = 3;
  localparam int          HALF  = 20;   // SCL half period in clk cycles

  logic             clk = 1'b0;
  logic             rst_n;
  logic             scl_m, sda_m;
  logic             sda_bus;
  logic             sda_oe, wr_stb, busy;
  logic [PTR_W-1:0] wr_addr, dbg_addr;
  logic [7:0]       wr_data, dbg_data;

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and target.
  assign sda_bus = sda_m & ~sda_oe;

  i2c_cfg_responder #(.DEV_ADDR(7'h76), .PTR_W(PTR_W), .FILT(FILT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .busy     (busy)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [PTR_W-1:0] a;
    logic [7:0]       d;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [7:0] exp_rx_q[$];
  string      exp_tag_q[$];
  event       obs_ev;
  logic [7:0] obs_val;
  logic       watch_oe = 1'b0;
  int         oe_viol  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-strobe monitor.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && wr_stb === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_stb_unexpected: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("wr_stb_addr_data", {wr_addr, wr_data}, {e.a, e.d});
      end
    end
  end

  // Bus response monitor: ACK bits and read bytes seen on SDA.
  initial forever begin
    @(obs_ev);
    if (exp_rx_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL rx_unexpected: got 0x%0h expected nothing", obs_val);
    end else begin
      logic [7:0] e;
      string      t;
      e = exp_rx_q.pop_front();
      t = exp_tag_q.pop_front();
      check(t, obs_val, e);
    end
  end

  always @(negedge clk) if (watch_oe && sda_oe) oe_viol++;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b, input bit glitch);
    sda_m = b;
    wait_clk(HALF / 2);
    scl_m = 1'b1;
    if (glitch) begin
      wait_clk(8);
      scl_m = 1'b0;
      wait_clk(2);
      scl_m = 1'b1;
      wait_clk(HALF - 10);
    end else begin
      wait_clk(HALF);
    end
    scl_m = 1'b0;
    wait_clk(HALF / 2);
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1;
    wait_clk(HALF / 2);
    scl_m = 1'b1;
    wait_clk(HALF / 2);
    b = sda_bus;
    wait_clk(HALF / 2);
    scl_m = 1'b0;
    wait_clk(HALF / 2);
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_clk(HALF / 2);
    scl_m = 1'b1;
    wait_clk(HALF);
    sda_m = 1'b0;
    wait_clk(HALF);
    scl_m = 1'b0;
    wait_clk(HALF / 2);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_clk(HALF / 2);
    scl_m = 1'b1;
    wait_clk(HALF);
    sda_m = 1'b1;
    wait_clk(HALF);
  endtask

  // Master sends a byte; expected ACK slot level (0=ACK, 1=NACK) is queued.
  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag,
                           input int glitch_bit = -1);
    logic a;
    exp_rx_q.push_back({7'd0, exp_ack});
    exp_tag_q.push_back(tag);
    for (int i = 7; i >= 0; i--) bit_out(b[i], i == glitch_bit);
    bit_in(a);
    obs_val = {7'd0, a};
    -> obs_ev;
  endtask

  // Master reads a byte, then answers ACK (nack=0) or NACK (nack=1).
  task automatic recv_byte(input logic [7:0] exp, input logic nack, input string tag);
    logic [7:0] v;
    logic       b;
    exp_rx_q.push_back(exp);
    exp_tag_q.push_back(tag);
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      v[i] = b;
    end
    obs_val = v;
    -> obs_ev;
    bit_out(nack, 1'b0);
  endtask

  task automatic exp_write(input logic [PTR_W-1:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr_q.push_back(e);
  endtask

  task automatic dbg_check(input logic [PTR_W-1:0] a, input logic [7:0] e, input string name);
    dbg_addr = a;
    #1;
    check(name, dbg_data, e);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    dbg_addr = '0;
    wait_clk(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_clk(20);

    // 1: single write
    start_cond();
    send_byte(8'hEC, 1'b0, "t1_addr_ack");
    send_byte(8'h21, 1'b0, "t1_ptr_ack");
    exp_write(6'h21, 8'h09);
    send_byte(8'h09, 1'b0, "t1_data_ack");
    check("t1_busy_mid", busy, 1);
    stop_cond();
    wait_clk(20);
    dbg_check(6'h21, 8'h09, "t1_dbg_21");
    check("t1_busy_after_stop", busy, 0);

    // 2: burst write wrapping the pointer, plus seed bank[0x22]
    start_cond();
    send_byte(8'hEC, 1'b0, "t2_addr_ack");
    send_byte(8'h3F, 1'b0, "t2_ptr_ack");
    exp_write(6'h3F, 8'hAA);
    send_byte(8'hAA, 1'b0, "t2_d0_ack");
    exp_write(6'h00, 8'h55);
    send_byte(8'h55, 1'b0, "t2_d1_ack");
    stop_cond();
    wait_clk(20);
    dbg_check(6'h3F, 8'hAA, "t2_dbg_3f");
    dbg_check(6'h00, 8'h55, "t2_dbg_00");
    start_cond();
    send_byte(8'hEC, 1'b0, "t2b_addr_ack");
    send_byte(8'h22, 1'b0, "t2b_ptr_ack");
    exp_write(6'h22, 8'hC3);
    send_byte(8'hC3, 1'b0, "t2b_data_ack");
    stop_cond();
    wait_clk(20);

    // 3: combined read with repeated start
    start_cond();
    send_byte(8'hEC, 1'b0, "t3_addr_ack");
    send_byte(8'h21, 1'b0, "t3_ptr_ack");
    start_cond();
    send_byte(8'hED, 1'b0, "t3_rd_addr_ack");
    recv_byte(8'h09, 1'b0, "t3_rd_byte0");
    recv_byte(8'hC3, 1'b1, "t3_rd_byte1");
    check("t3_sda_released", sda_oe, 0);
    stop_cond();
    wait_clk(20);
    // pointer persists across STOP and did not advance on NACK
    start_cond();
    send_byte(8'hED, 1'b0, "t3b_rd_addr_ack");
    recv_byte(8'hC3, 1'b1, "t3b_rd_persist");
    stop_cond();
    wait_clk(20);

    // 4: address mismatch
    watch_oe = 1'b1;
    check("t4_busy_before", busy, 0);
    start_cond();
    check("t4_busy_during", busy, 1);
    send_byte(8'hA0, 1'b1, "t4_addr_nack");
    send_byte(8'h00, 1'b1, "t4_byte_nack");
    stop_cond();
    wait_clk(20);
    watch_oe = 1'b0;
    check("t4_oe_never_driven", oe_viol, 0);
    check("t4_busy_after", busy, 0);

    // 5: SCL glitch inside a data byte
    start_cond();
    send_byte(8'hEC, 1'b0, "t5_addr_ack");
    send_byte(8'h10, 1'b0, "t5_ptr_ack");
    exp_write(6'h10, 8'h5A);
    send_byte(8'h5A, 1'b0, "t5_data_ack", 3);
    stop_cond();
    wait_clk(20);
    dbg_check(6'h10, 8'h5A, "t5_dbg_10");

    // 6: reset while the target drives a read bit (bank[0x21]=0x09, MSB 0)
    start_cond();
    send_byte(8'hEC, 1'b0, "t6_addr_ack");
    send_byte(8'h21, 1'b0, "t6_ptr_ack");
    start_cond();
    send_byte(8'hED, 1'b0, "t6_rd_addr_ack");
    n = 0;
    while (sda_oe !== 1'b1 && n < 40) begin
      wait_clk(1);
      n++;
    end
    check("t6_oe_driven_before_reset", sda_oe, 1);
    rst_n = 1'b0;
    wait_clk(1);
    check("t6_oe_released", sda_oe, 0);
    check("t6_busy_cleared", busy, 0);
    check("t6_wr_addr_cleared", wr_addr, 0);
    check("t6_wr_data_cleared", wr_data, 0);
    dbg_check(6'h21, 8'h00, "t6_bank_cleared");
    rst_n = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(30);
    start_cond();
    send_byte(8'hEC, 1'b0, "t6_fresh_addr_ack");
    send_byte(8'h05, 1'b0, "t6_fresh_ptr_ack");
    exp_write(6'h05, 8'h77);
    send_byte(8'h77, 1'b0, "t6_fresh_d0_ack");
    exp_write(6'h06, 8'h78);
    send_byte(8'h78, 1'b0, "t6_fresh_d1_ack");
    stop_cond();
    wait_clk(20);
    start_cond();
    send_byte(8'hEC, 1'b0, "t6_rb_addr_ack");
    send_byte(8'h05, 1'b0, "t6_rb_ptr_ack");
    start_cond();
    send_byte(8'hED, 1'b0, "t6_rb_rd_addr_ack");
    recv_byte(8'h77, 1'b0, "t6_rb_byte0");
    recv_byte(8'h78, 1'b1, "t6_rb_byte1");
    stop_cond();
    wait_clk(50);

    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
